arb_n_service: RTL and testbench
================================

# arb_n_service

N-input arbiter with per-input buffering, multiplexing NUM_IN valid/ready channels onto one output channel. It is the parametrised successor to the two-input arbitration service: configurable channel count, width and depth, round-robin or fixed-priority mode, and optional packet locking so multi-beat messages are never interleaved. It sits between the request-side service shims and a shared downstream consumer, one clock domain.

## Interface
- NUM_IN, 4: number of input channels, 2..16.
- DWIDTH, 8: data bits per beat.
- DEPTH, 16: entries per input FIFO, power of two, >= 2.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- PKT_MODE, 0: 1 = hold grant from first beat until a beat with last = 1; 0 = arbitrate every beat.
- SW = $clog2(NUM_IN) (localparam).

- Clk  in  1  single clock, all logic on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- in_data  in  NUM_IN*DWIDTH  channel i occupies bits [i*DWIDTH +: DWIDTH].
- in_last  in  NUM_IN  end-of-message flag per channel.
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready = FIFO i not full.
- out_data  out  DWIDTH  granted beat.
- out_last  out  1  last flag of granted beat.
- out_src  out  SW  index of the channel that supplied the current beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.

## Operation
- Each input has a FIFO of DEPTH entries storing {last, data}. Push on in_valid[i] & in_ready[i].
- in_ready[i] is registered-count based: low when count == DEPTH, even if the FIFO pops the same cycle (no full-bypass).
- No empty-bypass: a beat pushed in cycle k is eligible for arbitration from cycle k+1.
- Output register {out_data, out_last, out_src, out_valid}. It loads when (!out_valid | out_ready) and at least one eligible FIFO is non-empty. The load pops the granted FIFO in the same edge. When no FIFO is eligible, out_valid clears if the held beat was consumed.
- RR_MODE=1: pointer ptr holds the last granted index. The search starts at ptr+1 and wraps modulo NUM_IN. On each load, ptr <= granted index.
- RR_MODE=0: grant goes to the lowest-index non-empty eligible FIFO. ptr is unused.
- PKT_MODE=1:
  - Loading a beat with last = 0 sets lock with lock_src = granted index.
  - While locked, only lock_src is eligible. The output stalls if that FIFO is empty, even when other FIFOs hold data.
  - Loading a beat with last = 1 from lock_src clears lock.
- PKT_MODE=0: lock is never set. in_last is passed through unmodified.
- Count arithmetic uses $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset (Rst_n low at a rising edge), taking effect from the following cycle:
  - all FIFOs empty; in_ready all 0 while Rst_n low, all 1 the cycle after release
  - out_valid 0, out_data 0, out_last 0, out_src 0
  - ptr = NUM_IN-1, so the first round-robin grant is channel 0
  - lock cleared
- Reset mid-packet or mid-backpressure discards all buffered beats and the held output beat.
- Latency: push at edge k into an idle block gives out_valid high after edge k+1, i.e. 2 cycles from input handshake to output valid.
- Throughput: 1 beat/cycle sustained when out_ready stays high and any eligible FIFO is non-empty.
- out_data, out_last and out_src are stable while out_valid & !out_ready.
- Simultaneous push and pop on the same non-full FIFO: count unchanged.

## Structure
- Package arb_pkg holds:
  - the per-entry struct template {last, data}, expressed as a width function of DWIDTH
  - localparam helpers for SW and count width
  - the mode constants ARB_RR and ARB_FIXED
- Sub-module arb_fifo_sc: single-clock FIFO with synchronous active-low reset, parameters WIDTH and DEPTH, and ports push, pop, wdata, rdata, empty, full, count. Instantiated NUM_IN times with a generate loop.
- Grant logic (rotate, priority-pick, unrotate) and the lock state stay in the top-level module.

## Test plan
- Reset release, NUM_IN=4, RR: push 0xA1 on ch2 only -> out_valid 2 cycles later, out_data 0xA1, out_src 2, in_ready 4'b1111.
- RR fairness: all four FIFOs preloaded with 3 beats, out_ready = 1 -> out_src sequence 0,1,2,3,0,1,2,3,0,1,2,3, no idle cycles.
- Fixed priority (RR_MODE=0): ch0 and ch3 continuously valid -> only ch0 beats appear until ch0 goes idle, then ch3.
- Backpressure/full: DEPTH=16, out_ready = 0, push 17 beats on ch1 -> 1 beat held in the output register, 16 in the FIFO, in_ready[1] low. The 18th beat is not accepted. Output is held stable. Releasing out_ready drains all 17 in order.
- PKT_MODE=1: ch0 sends a 3-beat message with a one-cycle gap before beat 3, while ch1 holds a 1-beat message -> output is ch0, ch0, (stall), ch0(last), ch1. No interleave.
- Reset mid-packet: assert Rst_n low while locked on ch2 with 5 beats buffered -> next cycle out_valid 0 and all FIFOs empty. After release, the first grant is ch0 when ch0 and ch2 are both valid.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, mode constants and sizing helpers for the N-input arbitration service.
package arb_pkg;

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

    // A FIFO entry is {last, data}, so its width follows the data width.
    function automatic int entry_w(input int dwidth);
        return dwidth + 1;
    endfunction

    function automatic int sel_w(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/arb_fifo_sc.sv
// Single-clock FIFO with registered occupancy count; no bypass in either direction.
module arb_fifo_sc
    import arb_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_n_service.sv
// N-input buffered arbiter: per-channel FIFOs, round-robin or fixed-priority grant,
// optional packet locking, and a single registered output channel.
module arb_n_service
    import arb_pkg::*;
#(
    parameter int  NUM_IN   = 4,
    parameter int  DWIDTH   = 8,
    parameter int  DEPTH    = 16,
    parameter bit  RR_MODE  = ARB_RR,
    parameter bit  PKT_MODE = 1'b0,
    localparam int SW       = sel_w(NUM_IN)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_last,
    output logic [SW-1:0]            out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int EW = entry_w(DWIDTH);
    localparam int CW = cnt_w(DEPTH);

    logic [NUM_IN-1:0] fifo_push;
    logic [NUM_IN-1:0] fifo_pop;
    logic [NUM_IN-1:0] fifo_empty;
    logic [NUM_IN-1:0] fifo_full;
    logic [EW-1:0]     fifo_rdata [NUM_IN];
    logic [CW-1:0]     fifo_count [NUM_IN];

    logic [SW-1:0]     ptr;
    logic [SW-1:0]     grant;
    logic [EW-1:0]     grant_entry;
    logic              grant_last;
    logic [NUM_IN-1:0] eligible;
    logic              any_eligible;
    logic              load;

    lock_state_t       lock_state;
    lock_state_t       lock_state_next;
    logic [SW-1:0]     lock_src;
    logic [SW-1:0]     lock_src_next;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_ch
            assign in_ready[g]  = Rst_n & ~fifo_full[g];
            assign fifo_push[g] = in_valid[g] & in_ready[g];

            arb_fifo_sc #(
                .WIDTH (EW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (Clk),
                .rst_n (Rst_n),
                .push  (fifo_push[g]),
                .pop   (fifo_pop[g]),
                .wdata ({in_last[g], in_data[g*DWIDTH +: DWIDTH]}),
                .rdata (fifo_rdata[g]),
                .empty (fifo_empty[g]),
                .full  (fifo_full[g]),
                .count (fifo_count[g])
            );

            // in_ready follows the full flag; it must never disagree with the count.
            assert property (@(posedge Clk) disable iff (!Rst_n)
                fifo_full[g] == (fifo_count[g] == CW'(DEPTH)));
        end
    endgenerate

    // While a packet is locked only its source may be granted, even if others hold data.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = !fifo_empty[i] &&
                          ((lock_state == LK_OPEN) || (lock_src == SW'(i)));
        end
    end

    // Rotate so the search starts after the last grant, pick lowest, then unrotate.
    always_comb begin
        int                start;
        int                pick;
        logic [NUM_IN-1:0] rot;
        logic [SW-1:0]     idx;

        start = (RR_MODE == ARB_RR) ? ((int'(ptr) + 1) % NUM_IN) : 0;
        rot   = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            idx    = SW'((start + j) % NUM_IN);
            rot[j] = eligible[idx];
        end
        pick = 0;
        for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick = j;
            end
        end
        grant        = SW'((start + pick) % NUM_IN);
        any_eligible = |eligible;
    end

    assign grant_entry = fifo_rdata[grant];
    assign grant_last  = grant_entry[DWIDTH];

    always_comb begin
        load     = (!out_valid || out_ready) && any_eligible;
        fifo_pop = '0;
        if (load) begin
            fifo_pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_entry[DWIDTH-1:0];
            out_last  <= grant_last;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Reset value makes channel 0 the first round-robin winner.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr <= SW'(NUM_IN - 1);
        end else if (load && (RR_MODE == ARB_RR)) begin
            ptr <= grant;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            lock_state <= LK_OPEN;
            lock_src   <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_src   <= lock_src_next;
        end
    end

    always_comb begin
        lock_state_next = lock_state;
        lock_src_next   = lock_src;
        if (PKT_MODE && load) begin
            case (lock_state)
                LK_OPEN: begin
                    if (!grant_last) begin
                        lock_state_next = LK_HELD;
                        lock_src_next   = grant;
                    end
                end
                LK_HELD: begin
                    if (grant_last) begin
                        lock_state_next = LK_OPEN;
                    end
                end
                default: lock_state_next = LK_OPEN;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_n_service.sv
// Scoreboard bench for arb_n_service: one round-robin/packet instance and one fixed-priority instance.
`timescale 1ns/1ps
module tb_arb_n_service;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SW    = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic [N*DW-1:0] a_in_data, b_in_data;
    logic [N-1:0]    a_in_last, a_in_valid, a_in_ready;
    logic [N-1:0]    b_in_last, b_in_valid, b_in_ready;
    logic [DW-1:0]   a_out_data, b_out_data;
    logic            a_out_last, b_out_last;
    logic [SW-1:0]   a_out_src, b_out_src;
    logic            a_out_valid, b_out_valid;
    logic            a_out_ready, b_out_ready;

    arb_n_service #(
        .NUM_IN(N), .DWIDTH(DW), .DEPTH(DEPTH), .RR_MODE(1'b1), .PKT_MODE(1'b1)
    ) dut_a (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(a_in_data), .in_last(a_in_last), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_last(a_out_last), .out_src(a_out_src),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    arb_n_service #(
        .NUM_IN(N), .DWIDTH(DW), .DEPTH(DEPTH), .RR_MODE(1'b0), .PKT_MODE(1'b0)
    ) dut_b (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(b_in_data), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_last(b_out_last), .out_src(b_out_src),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int    n_checks = 0;
    int    n_fails  = 0;
    int    hs_a     = 0;
    int    hs_b     = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];

    function automatic beat_t mk(input int src, input logic last, input int data);
        beat_t b;
        b.src  = SW'(src);
        b.last = last;
        b.data = DW'(data);
        return b;
    endfunction

    // Output monitors: pop the scoreboard on every handshake, and require a stalled beat to hold.
    beat_t got_a, want_a, held_a;
    logic  hold_a = 1'b0;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            hold_a = 1'b0;
        end else begin
            got_a = {a_out_src, a_out_last, a_out_data};
            if (hold_a) begin
                n_checks++;
                if (a_out_valid !== 1'b1 || got_a !== held_a) begin
                    n_fails++;
                    $display("FAIL a_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                             a_out_valid, got_a, held_a);
                end
            end
            if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
                hs_a++;
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fails++;
                    $display("FAIL a_unexpected: got beat=%h, required no beat", got_a);
                end else begin
                    want_a = exp_a.pop_front();
                    if (got_a !== want_a) begin
                        n_fails++;
                        $display("FAIL a_beat: got src=%0d last=%b data=%h, required src=%0d last=%b data=%h",
                                 got_a.src, got_a.last, got_a.data, want_a.src, want_a.last, want_a.data);
                    end
                end
            end
            hold_a = a_out_valid && !a_out_ready;
            held_a = got_a;
        end
    end

    beat_t got_b, want_b, held_b;
    logic  hold_b = 1'b0;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            hold_b = 1'b0;
        end else begin
            got_b = {b_out_src, b_out_last, b_out_data};
            if (hold_b) begin
                n_checks++;
                if (b_out_valid !== 1'b1 || got_b !== held_b) begin
                    n_fails++;
                    $display("FAIL b_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                             b_out_valid, got_b, held_b);
                end
            end
            if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
                hs_b++;
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fails++;
                    $display("FAIL b_unexpected: got beat=%h, required no beat", got_b);
                end else begin
                    want_b = exp_b.pop_front();
                    if (got_b !== want_b) begin
                        n_fails++;
                        $display("FAIL b_beat: got src=%0d last=%b data=%h, required src=%0d last=%b data=%h",
                                 got_b.src, got_b.last, got_b.data, want_b.src, want_b.last, want_b.data);
                    end
                end
            end
            hold_b = b_out_valid && !b_out_ready;
            held_b = got_b;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_in_valid = '0; a_in_last = '0; a_in_data = '0;
        b_in_valid = '0; b_in_last = '0; b_in_data = '0;
    endtask

    task automatic set_a(input int ch, input int d, input logic l);
        a_in_valid[ch]          = 1'b1;
        a_in_data[ch*DW +: DW]  = DW'(d);
        a_in_last[ch]           = l;
    endtask

    task automatic set_b(input int ch, input int d, input logic l);
        b_in_valid[ch]          = 1'b1;
        b_in_data[ch*DW +: DW]  = DW'(d);
        b_in_last[ch]           = l;
    endtask

    task automatic do_reset();
        idle_inputs();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
        step();
    endtask

    task automatic wait_drain_a(input int budget);
        int left = budget;
        while (exp_a.size() != 0 && left > 0) begin
            step();
            left--;
        end
        repeat (3) step();
    endtask

    task automatic wait_drain_b(input int budget);
        int left = budget;
        while (exp_b.size() != 0 && left > 0) begin
            step();
            left--;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        Rst_n = 1'b0;
        step();
        step();
        @(negedge Clk);
        n_checks++;
        if (a_in_ready !== 4'b0000 || b_in_ready !== 4'b0000) begin
            n_fails++;
            $display("FAIL rst_in_ready_low: got a=%b b=%b, required 0000", a_in_ready, b_in_ready);
        end
        n_checks++;
        if ({a_out_valid, a_out_last, a_out_src, a_out_data} !== '0 ||
            {b_out_valid, b_out_last, b_out_src, b_out_data} !== '0) begin
            n_fails++;
            $display("FAIL rst_outputs: got a=%b/%b/%0d/%h b=%b, required all zero",
                     a_out_valid, a_out_last, a_out_src, a_out_data, b_out_valid);
        end
        step();
        Rst_n = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (a_in_ready !== 4'b1111 || b_in_ready !== 4'b1111) begin
            n_fails++;
            $display("FAIL rst_release_ready: got a=%b b=%b, required 1111", a_in_ready, b_in_ready);
        end
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_release_valid: got %b, required 0", a_out_valid);
        end
        step();
    endtask

    task automatic test_latency();
        do_reset();
        a_out_ready = 1'b1;
        set_a(2, 8'hA1, 1'b1);
        exp_a.push_back(mk(2, 1'b1, 8'hA1));
        step();
        idle_inputs();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL lat_no_bypass: got out_valid=%b, required 0", a_out_valid);
        end
        step();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_src !== 2'd2 || a_out_data !== 8'hA1) begin
            n_fails++;
            $display("FAIL lat_first_beat: got valid=%b src=%0d data=%h, required 1/2/a1",
                     a_out_valid, a_out_src, a_out_data);
        end
        n_checks++;
        if (a_in_ready !== 4'b1111) begin
            n_fails++;
            $display("FAIL lat_in_ready: got %b, required 1111", a_in_ready);
        end
        step();
        wait_drain_a(10);
        n_checks++;
        if (exp_a.size() != 0) begin
            n_fails++;
            $display("FAIL lat_drain: got %0d outstanding, required 0", exp_a.size());
        end
    endtask

    task automatic test_rr_fairness();
        int hs0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int ch = 0; ch < N; ch++) begin
                set_a(ch, 16 * ch + r, 1'b1);
                exp_a.push_back(mk(ch, 1'b1, 16 * ch + r));
            end
            step();
        end
        idle_inputs();
        hs0 = hs_a;
        a_out_ready = 1'b1;
        repeat (12) step();
        n_checks++;
        if (hs_a - hs0 != 12) begin
            n_fails++;
            $display("FAIL rr_no_idle: got %0d beats in 12 cycles, required 12", hs_a - hs0);
        end
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || exp_a.size() != 0) begin
            n_fails++;
            $display("FAIL rr_done: got valid=%b outstanding=%0d, required 0/0", a_out_valid, exp_a.size());
        end
        step();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        b_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            set_b(0, n, n[0]);
            set_b(3, 8'h30 + n, ~n[0]);
            exp_b.push_back(mk(0, n[0], n));
            step();
        end
        idle_inputs();
        for (int n = 0; n < 6; n++) begin
            exp_b.push_back(mk(3, ~n[0], 8'h30 + n));
        end
        wait_drain_b(40);
        n_checks++;
        if (exp_b.size() != 0) begin
            n_fails++;
            $display("FAIL fp_drain: got %0d outstanding, required 0", exp_b.size());
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        do_reset();
        hs0 = hs_a;
        for (int n = 0; n < 17; n++) begin
            n_checks++;
            if (a_in_ready[1] !== 1'b1) begin
                n_fails++;
                $display("FAIL bp_accept_%0d: got in_ready[1]=%b, required 1", n, a_in_ready[1]);
            end
            set_a(1, 8'h40 + n, 1'b1);
            exp_a.push_back(mk(1, 1'b1, 8'h40 + n));
            step();
        end
        idle_inputs();
        @(negedge Clk);
        n_checks++;
        if (a_in_ready[1] !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_full: got in_ready[1]=%b, required 0", a_in_ready[1]);
        end
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_src !== 2'd1 || a_out_data !== 8'h40) begin
            n_fails++;
            $display("FAIL bp_held: got valid=%b src=%0d data=%h, required 1/1/40",
                     a_out_valid, a_out_src, a_out_data);
        end
        step();
        set_a(1, 8'hEE, 1'b1);
        step();
        idle_inputs();
        step();
        a_out_ready = 1'b1;
        wait_drain_a(60);
        n_checks++;
        if (exp_a.size() != 0 || hs_a - hs0 != 17) begin
            n_fails++;
            $display("FAIL bp_drain: got %0d beats, %0d outstanding, required 17/0",
                     hs_a - hs0, exp_a.size());
        end
    endtask

    task automatic test_packet();
        do_reset();
        a_out_ready = 1'b1;
        set_a(0, 8'h01, 1'b0);
        set_a(1, 8'h11, 1'b1);
        exp_a.push_back(mk(0, 1'b0, 8'h01));
        exp_a.push_back(mk(0, 1'b0, 8'h02));
        exp_a.push_back(mk(0, 1'b1, 8'h03));
        exp_a.push_back(mk(1, 1'b1, 8'h11));
        step();
        idle_inputs();
        set_a(0, 8'h02, 1'b0);
        step();
        idle_inputs();
        step();
        set_a(0, 8'h03, 1'b1);
        step();
        idle_inputs();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL pkt_stall: got out_valid=%b src=%0d, required 0 while locked on empty ch0",
                     a_out_valid, a_out_src);
        end
        wait_drain_a(20);
        n_checks++;
        if (exp_a.size() != 0) begin
            n_fails++;
            $display("FAIL pkt_drain: got %0d outstanding, required 0", exp_a.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            set_a(2, 8'h20 + n, 1'b0);
            step();
        end
        idle_inputs();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_src !== 2'd2) begin
            n_fails++;
            $display("FAIL mid_pre: got valid=%b src=%0d, required 1/2", a_out_valid, a_out_src);
        end
        step();
        Rst_n = 1'b0;
        step();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 4'b0000 || a_out_data !== 8'h00) begin
            n_fails++;
            $display("FAIL mid_rst: got valid=%b ready=%b data=%h, required 0/0000/00",
                     a_out_valid, a_in_ready, a_out_data);
        end
        step();
        Rst_n = 1'b1;
        step();
        @(negedge Clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 4'b1111) begin
            n_fails++;
            $display("FAIL mid_empty: got valid=%b ready=%b, required 0/1111", a_out_valid, a_in_ready);
        end
        a_out_ready = 1'b1;
        step();
        set_a(0, 8'h0C, 1'b1);
        set_a(2, 8'h2C, 1'b1);
        exp_a.push_back(mk(0, 1'b1, 8'h0C));
        exp_a.push_back(mk(2, 1'b1, 8'h2C));
        step();
        idle_inputs();
        wait_drain_a(20);
        n_checks++;
        if (exp_a.size() != 0) begin
            n_fails++;
            $display("FAIL mid_after: got %0d outstanding, required 0", exp_a.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        test_reset();
        test_latency();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_packet();
        test_reset_mid_packet();
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fails++;
            $display("FAIL final_queues: got a=%0d b=%0d outstanding, required 0/0", exp_a.size(), exp_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
